touch_tap: RTL and testbench
============================

# touch_tap

Parametrised multi-channel input conditioner for touch pads and push-buttons. It replaces the plain pass-through tap with per-channel synchronisation, debouncing, press/release edge events and long-press detection. It sits between the board-level touch/button pins and the control logic, which consumes clean levels and single-cycle event pulses.

## Interface
- `N_CH`, 4: number of independent input channels.
- `DEBOUNCE_CYC`, 16: consecutive stable cycles needed to accept a level change. Must be ≥ 1.
- `LONG_CYC`, 1024: cycles of continuous debounced press before a long-press event. Must be > `DEBOUNCE_CYC`.
- `CNT_W`, `$clog2(LONG_CYC+1)`: width of the per-channel counter. Derived; do not override.

Ports:
- `clk`  in  1  single system clock.
- `rst_n`  in  1  reset; **asynchronous, active-low**.
- `touch_in`  in  N_CH  raw, asynchronous pad levels; 1 means touched.
- `touch_out`  out  N_CH  debounced level per channel.
- `press_pulse`  out  N_CH  one-cycle pulse when the debounced level rises.
- `release_pulse`  out  N_CH  one-cycle pulse when the debounced level falls.
- `long_pulse`  out  N_CH  one-cycle pulse, once per hold, after `LONG_CYC` cycles held.
- `enable`  in  N_CH  per-channel enable. When 0, the channel is forced to IDLE, its outputs are 0 and no pulses are produced.

## Operation
- **Synchroniser:** each channel passes through a 2-flop synchroniser (`s1`, `s2`); both flops reset to 0. All logic below uses `s2`.
- **Per-channel FSM** with states IDLE, PRESS_CHK, HELD, RELEASE_CHK, driven by counter `cnt`.
  - IDLE: `touch_out`=0. If `s2`=1, go to PRESS_CHK with `cnt`=1.
  - PRESS_CHK: if `s2`=0, return to IDLE with `cnt`=0 (glitch rejected, no pulse). Otherwise increment `cnt`. When `cnt` reaches `DEBOUNCE_CYC`, go to HELD, set `cnt`=0, and assert `press_pulse` for one cycle.
  - HELD: `touch_out`=1. `cnt` counts up and saturates at `LONG_CYC`. When it first reaches `LONG_CYC`, assert `long_pulse` for one cycle. If `s2`=0, go to RELEASE_CHK with `cnt`=1; the long-press progress is kept in a separate `long_done` flag.
  - RELEASE_CHK: `touch_out` stays 1. If `s2`=1, return to HELD. The long counter restarts from 0 unless `long_done` is set, so a bounce during release never re-fires `long_pulse`. When `cnt` reaches `DEBOUNCE_CYC`, go to IDLE, assert `release_pulse`, and clear `long_done`.
- **Pulse exclusivity:** `press_pulse`, `long_pulse` and `release_pulse` of one channel are mutually exclusive in any cycle.
- **Independence:** channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- **Enable:**
  - Deasserting `enable` mid-hold sends the channel to IDLE without a `release_pulse`.
  - Re-enabling while the pad is held produces a fresh press after debounce.

## Timing
- **Reset values:** every output is 0 during reset. FSM = IDLE, `cnt` = 0, `long_done` = 0.
- **Press latency:** raw rise sampled at edge t, pad held stable afterwards.
  - `s2` is 1 after edge t+1.
  - PRESS_CHK is entered at edge t+2.
  - `touch_out`=1 and `press_pulse`=1 during the cycle after edge t+1+`DEBOUNCE_CYC`.
- **Release latency:** same structure; `touch_out` falls `DEBOUNCE_CYC`+2 cycles after the raw fall.
- **Long-press latency:** `long_pulse` is high `LONG_CYC` cycles after `press_pulse`.
- **Pulse width:** every pulse is exactly one cycle wide and registered (no combinational path from `touch_in`).
- **Minimum debounce:** `DEBOUNCE_CYC`=1 accepts a level held for a single synchronised cycle.
- **Reset mid-hold:** takes effect asynchronously with no pulses. After release of reset, a still-held pad is re-debounced as a new press.

## Structure
- **Package `touch_tap_pkg`:** FSM state enum `tap_state_t` (2-bit) and the `SYNC_STAGES` = 2 constant.
- **Sub-module `touch_tap_ch`:** one channel (synchroniser, FSM, counter, `long_done`) with scalar ports. `touch_tap` instantiates `N_CH` copies in a generate loop.

## Test plan
All scenarios use `N_CH`=2, `DEBOUNCE_CYC`=4, `LONG_CYC`=16.
- **Clean press:** ch0 raw 0→1 at edge 10 and held → `touch_out[0]`=1 and `press_pulse[0]` high for exactly one cycle after edge 15; ch1 stays 0.
- **Glitch rejection:** ch0 raw high for 3 cycles, then low → no pulse; `touch_out[0]` stays 0 throughout.
- **Long press with release bounce:** hold ch0 for 40 cycles → `long_pulse` once, 16 cycles after `press_pulse`. A 2-cycle release bounce is followed by a final release → exactly one `release_pulse`, 6 cycles after the final raw fall, and no second `long_pulse`.
- **Simultaneous channels:** ch0 and ch1 rise at the same edge → `press_pulse`=2'b11 in the same cycle.
- **Reset mid-hold:** `rst_n` low during HELD → all outputs 0 immediately. After reset release with the pad still held → new `press_pulse` 6 cycles later.
- **Enable gating:** clear `enable[1]` while ch1 is held → `touch_out[1]`=0 next cycle, no `release_pulse`. Re-enable with the pad held → `press_pulse[1]` after debounce.

Source files
------------

// File: rtl/touch_tap_pkg.sv
// Shared types and constants for the touch_tap input conditioner.
package touch_tap_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPressChk,
    StHeld,
    StReleaseChk
  } tap_state_t;

  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/touch_tap_ch.sv
// One touch channel: synchroniser, debounce FSM, press/release/long-press pulses.
module touch_tap_ch
  import touch_tap_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned LONG_CYC     = 1024,
  parameter int unsigned CNT_W        = $clog2(LONG_CYC + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic touch_in,
  input  logic enable,
  output logic touch_out,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam logic [CNT_W-1:0] DebMax  = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] LongMax = CNT_W'(LONG_CYC);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam bit               DebOne  = (DEBOUNCE_CYC == 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s2;
  tap_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   long_done_q, long_done_d;
  logic                   touch_d, press_d, release_d, long_d;

  assign s2      = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt_q + CntOne;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    long_done_d = long_done_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    if (!enable) begin
      state_d     = StIdle;
      cnt_d       = '0;
      long_done_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (s2) begin
            // A single-cycle debounce accepts the level on its first sighting.
            if (DebOne) begin
              state_d = StHeld;
              cnt_d   = '0;
              press_d = 1'b1;
            end else begin
              state_d = StPressChk;
              cnt_d   = CntOne;
            end
          end
        end
        StPressChk: begin
          if (!s2) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_inc == DebMax) begin
            state_d = StHeld;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StHeld: begin
          if (!s2) begin
            if (DebOne) begin
              state_d     = StIdle;
              cnt_d       = '0;
              release_d   = 1'b1;
              long_done_d = 1'b0;
            end else begin
              state_d = StReleaseChk;
              cnt_d   = CntOne;
            end
          end else if (cnt_q != LongMax) begin
            cnt_d = cnt_inc;
            if (cnt_inc == LongMax && !long_done_q) begin
              long_d      = 1'b1;
              long_done_d = 1'b1;
            end
          end
        end
        StReleaseChk: begin
          if (s2) begin
            // Bounce back to held: a completed long press stays saturated.
            state_d = StHeld;
            cnt_d   = long_done_q ? LongMax : '0;
          end else if (cnt_inc == DebMax) begin
            state_d     = StIdle;
            cnt_d       = '0;
            release_d   = 1'b1;
            long_done_d = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
    touch_d = (state_d == StHeld) || (state_d == StReleaseChk);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= '0;
      state_q       <= StIdle;
      cnt_q         <= '0;
      long_done_q   <= 1'b0;
      touch_out     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], touch_in};
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      long_done_q   <= long_done_d;
      touch_out     <= touch_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
    end
  end

endmodule

// File: rtl/touch_tap.sv
// Multi-channel touch/button conditioner: N_CH independent debounced channels.
module touch_tap
  import touch_tap_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned LONG_CYC     = 1024,
  parameter int unsigned CNT_W        = $clog2(LONG_CYC + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] touch_in,
  input  logic [N_CH-1:0] enable,
  output logic [N_CH-1:0] touch_out,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    touch_tap_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .touch_in     (touch_in[g]),
      .enable       (enable[g]),
      .touch_out    (touch_out[g]),
      .press_pulse  (press_pulse[g]),
      .release_pulse(release_pulse[g]),
      .long_pulse   (long_pulse[g])
    );
  end

endmodule

// File: tb/tb_touch_tap.sv
// Scoreboard bench for touch_tap: expected pulse events queued with cycle stamps.
module tb_touch_tap;

  localparam int unsigned N_CH = 2;
  localparam int unsigned DEB  = 4;
  localparam int unsigned LNG  = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] touch_in;
  logic [N_CH-1:0] enable;
  logic [N_CH-1:0] touch_out;
  logic [N_CH-1:0] press_pulse;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] long_pulse;

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] lng;
  } ev_t;

  ev_t exp_q[$];
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;

  touch_tap #(
    .N_CH        (N_CH),
    .DEBOUNCE_CYC(DEB),
    .LONG_CYC    (LNG)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .touch_in     (touch_in),
    .enable       (enable),
    .touch_out    (touch_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle with any pulse must match the oldest expected event.
  always @(negedge clk) begin
    if ((|press_pulse) || (|release_pulse) || (|long_pulse)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d press=%b rel=%b long=%b", cyc, press_pulse,
                 release_pulse, long_pulse);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.cyc !== cyc || e.press !== press_pulse || e.rel !== release_pulse ||
            e.lng !== long_pulse) begin
          errors++;
          $display("FAIL pulse_event got cyc=%0d p=%b r=%b l=%b exp cyc=%0d p=%b r=%b l=%b",
                   cyc, press_pulse, release_pulse, long_pulse, e.cyc, e.press, e.rel, e.lng);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int c, input logic [1:0] p, input logic [1:0] r, input logic [1:0] l);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.lng = l;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    step(10);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_pulses got %0d pending, expected 0 (next cyc %0d)", name,
               exp_q.size(), exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; touch_in = '0; enable = '1;
    step(3);
    checks++;
    if ({touch_out, press_pulse, release_pulse, long_pulse} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 0",
               {touch_out, press_pulse, release_pulse, long_pulse});
    end
    rst_n = 1'b1;
    step(4);
    checks++;
    if (touch_out !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_touch got %b expected 00", touch_out);
    end
  endtask

  task automatic test_clean_press();
    int c;
    c = cyc; touch_in[0] = 1'b1;
    push(c + 6, 2'b01, 2'b00, 2'b00);
    step(5);
    checks++;
    if (touch_out !== 2'b00) begin
      errors++; $display("FAIL press_early_touch got %b expected 00", touch_out);
    end
    step(1);
    checks++;
    if (touch_out !== 2'b01) begin
      errors++; $display("FAIL press_touch got %b expected 01", touch_out);
    end
    step(2);
    c = cyc; touch_in[0] = 1'b0;
    push(c + 6, 2'b00, 2'b01, 2'b00);
    step(5);
    checks++;
    if (touch_out !== 2'b01) begin
      errors++; $display("FAIL release_early_touch got %b expected 01", touch_out);
    end
    step(1);
    checks++;
    if (touch_out !== 2'b00) begin
      errors++; $display("FAIL release_touch got %b expected 00", touch_out);
    end
    drain("clean_press");
  endtask

  task automatic test_glitch();
    touch_in[0] = 1'b1;
    step(3);
    touch_in[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks++;
      if (touch_out !== 2'b00) begin
        errors++; $display("FAIL glitch_touch step %0d got %b expected 00", i, touch_out);
      end
    end
    drain("glitch");
  endtask

  task automatic test_long_bounce();
    int c;
    c = cyc; touch_in[0] = 1'b1;
    push(c + 6, 2'b01, 2'b00, 2'b00);
    push(c + 6 + LNG, 2'b00, 2'b00, 2'b01);
    step(40);
    touch_in[0] = 1'b0;
    step(2);
    touch_in[0] = 1'b1;
    step(2);
    c = cyc; touch_in[0] = 1'b0;
    push(c + 6, 2'b00, 2'b01, 2'b00);
    step(5);
    checks++;
    if (touch_out !== 2'b01) begin
      errors++; $display("FAIL bounce_touch got %b expected 01", touch_out);
    end
    drain("long_bounce");
  endtask

  task automatic test_simultaneous();
    int c;
    c = cyc; touch_in = 2'b11;
    push(c + 6, 2'b11, 2'b00, 2'b00);
    step(7);
    checks++;
    if (touch_out !== 2'b11) begin
      errors++; $display("FAIL simul_touch got %b expected 11", touch_out);
    end
    c = cyc; touch_in = 2'b00;
    push(c + 6, 2'b00, 2'b11, 2'b00);
    drain("simultaneous");
  endtask

  task automatic test_reset_mid_hold();
    int c;
    c = cyc; touch_in[0] = 1'b1;
    push(c + 6, 2'b01, 2'b00, 2'b00);
    step(10);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({touch_out, press_pulse, release_pulse, long_pulse} !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold_outputs got %b expected 0",
               {touch_out, press_pulse, release_pulse, long_pulse});
    end
    step(2);
    c = cyc; rst_n = 1'b1;
    push(c + 6, 2'b01, 2'b00, 2'b00);
    step(5);
    checks++;
    if (touch_out !== 2'b00) begin
      errors++; $display("FAIL rehold_early_touch got %b expected 00", touch_out);
    end
    step(1);
    checks++;
    if (touch_out !== 2'b01) begin
      errors++; $display("FAIL rehold_touch got %b expected 01", touch_out);
    end
    c = cyc; touch_in[0] = 1'b0;
    push(c + 6, 2'b00, 2'b01, 2'b00);
    drain("reset_mid_hold");
  endtask

  task automatic test_enable();
    int c;
    c = cyc; touch_in[1] = 1'b1;
    push(c + 6, 2'b10, 2'b00, 2'b00);
    step(8);
    enable[1] = 1'b0;
    step(1);
    checks++;
    if (touch_out !== 2'b00) begin
      errors++; $display("FAIL disable_touch got %b expected 00", touch_out);
    end
    step(3);
    c = cyc; enable[1] = 1'b1;
    push(c + 4, 2'b10, 2'b00, 2'b00);
    step(4);
    checks++;
    if (touch_out !== 2'b10) begin
      errors++; $display("FAIL reenable_touch got %b expected 10", touch_out);
    end
    c = cyc; touch_in[1] = 1'b0;
    push(c + 6, 2'b00, 2'b10, 2'b00);
    drain("enable");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_long_bounce();
    test_simultaneous();
    test_reset_mid_hold();
    test_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
